// File: rtl/addr_gen_pkg.sv
// addr_gen_pkg: shared types for the 2-D strided address generator scheduler.
//   W_DEF      default datapath width of config fields, counters and address
//   state_t    scheduler FSM states
//   scan_cfg_t latched loop configuration of one requester
package addr_gen_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [W_DEF-1:0] x_max;
        logic [W_DEF-1:0] y_max;
        logic [W_DEF-1:0] x_strd;
        logic [W_DEF-1:0] y_strd;
        logic [W_DEF-1:0] offset;
    } scan_cfg_t;

endpackage

// File: rtl/addr_gen_sched_if.sv
// addr_gen_sched_if: address beat stream from the scheduler to the memory port.
//   addr_valid  beat valid (master)
//   addr_ready  consumer accepts beat (slave)
//   addr_out    address of the beat
//   addr_last   final beat of the scan
//   addr_id     index of the requester that owns the scan
interface addr_gen_sched_if #(
    parameter int W    = 16,
    parameter int ID_W = 1
);
    logic            addr_valid;
    logic            addr_ready;
    logic [W-1:0]    addr_out;
    logic            addr_last;
    logic [ID_W-1:0] addr_id;

    modport master (
        output addr_valid, addr_out, addr_last, addr_id,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, addr_out, addr_last, addr_id,
        output addr_ready
    );
endinterface

// File: rtl/affine_scan2d.sv
// affine_scan2d: x/y nested counters plus stride accumulator.
//   clk, rst   clock, synchronous active-high reset
//   load       latch cfg and clear x, y, acc
//   cfg        loop configuration
//   step       advance one beat
//   addr       cfg.offset + acc (wraps)
//   x_at_max   inner counter is on its final column
//   last       current position is the final beat of the scan
module affine_scan2d
    import addr_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  scan_cfg_t        cfg,
    input  logic             step,
    output logic [W_DEF-1:0] addr,
    output logic             x_at_max,
    output logic             last
);
    scan_cfg_t        cfg_q;
    logic [W_DEF-1:0] x_q, y_q, acc_q;
    logic             y_at_max;

    // Compare against max-1 so extents of 2^W-1 work without a wider compare.
    assign x_at_max = (x_q == cfg_q.x_max - 1'b1);
    assign y_at_max = (y_q == cfg_q.y_max - 1'b1);
    assign last     = x_at_max && y_at_max;
    assign addr     = cfg_q.offset + acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else if (load) begin
            cfg_q <= cfg;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else if (step) begin
            if (x_at_max) begin
                // Row wrap: the outer stride replaces the inner one.
                x_q   <= '0;
                y_q   <= y_at_max ? '0 : y_q + 1'b1;
                acc_q <= acc_q + cfg_q.y_strd;
            end else begin
                x_q   <= x_q + 1'b1;
                acc_q <= acc_q + cfg_q.x_strd;
            end
        end
    end
endmodule

// File: rtl/addr_gen_sched.sv
// addr_gen_sched: shares one affine_scan2d between NREQ requesters.
// Round-robin arbitration in IDLE, streams the winner's scan, pulses done.
//   clk, rst     clock, synchronous active-high reset
//   req          level request per requester, sampled in IDLE only
//   cfg_*        per-requester loop config, slice i belongs to requester i
//   grant        one-hot owner, held from grant through DONE
//   busy         scheduler not IDLE
//   done         one-cycle one-hot completion pulse
//   aif          address beat stream (master side)
// W must equal W_DEF: the latched config struct is sized by the package.
module addr_gen_sched
    import addr_gen_pkg::*;
#(
    parameter  int W    = W_DEF,
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] cfg_x_max,
    input  logic [NREQ*W-1:0] cfg_y_max,
    input  logic [NREQ*W-1:0] cfg_x_strd,
    input  logic [NREQ*W-1:0] cfg_y_strd,
    input  logic [NREQ*W-1:0] cfg_offset,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [NREQ-1:0]   done,
    addr_gen_sched_if.master  aif
);
    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, id_q;
    logic [ID_W-1:0] win_idx, rr_next;
    logic            win_found;
    logic            load, step;
    logic            zero_ext;
    scan_cfg_t       sel_cfg;
    logic [W-1:0]    scan_addr;
    logic            scan_x_at_max, scan_last;

    // First asserted request at or after the rr pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_q) + i) % NREQ;
            if (!win_found && req[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[ID_W-1:0];
            end
        end
    end

    assign rr_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;

    always_comb begin
        sel_cfg.x_max  = cfg_x_max [win_idx*W +: W];
        sel_cfg.y_max  = cfg_y_max [win_idx*W +: W];
        sel_cfg.x_strd = cfg_x_strd[win_idx*W +: W];
        sel_cfg.y_strd = cfg_y_strd[win_idx*W +: W];
        sel_cfg.offset = cfg_offset[win_idx*W +: W];
    end

    // An empty extent skips RUN entirely and completes with zero beats.
    assign zero_ext = (sel_cfg.x_max == '0) || (sel_cfg.y_max == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = zero_ext ? DONE : RUN;
                end
            end
            RUN: begin
                step = aif.addr_ready;
                if (aif.addr_ready && scan_last) state_d = DONE;
            end
            DONE: begin
                done[id_q] = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            id_q  <= '0;
            rr_q  <= '0;
        end else if (load) begin
            grant          <= '0;
            grant[win_idx] <= 1'b1;
            id_q           <= win_idx;
            rr_q           <= rr_next;
        end else if (state_q == DONE) begin
            grant <= '0;
        end
    end

    affine_scan2d u_scan (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cfg      (sel_cfg),
        .step     (step),
        .addr     (scan_addr),
        .x_at_max (scan_x_at_max),
        .last     (scan_last)
    );

    assign busy           = (state_q != IDLE);
    assign aif.addr_valid = (state_q == RUN);
    assign aif.addr_out   = scan_addr;
    // last already implies the inner counter is at its final column.
    assign aif.addr_last  = aif.addr_valid && scan_x_at_max && scan_last;
    assign aif.addr_id    = id_q;
endmodule

// File: tb/tb_addr_gen_sched.sv
module tb_addr_gen_sched;
    localparam int W    = 16;
    localparam int NREQ = 2;
    localparam int ID_W = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] cfg_x_max, cfg_y_max, cfg_x_strd, cfg_y_strd, cfg_offset;
    logic [NREQ-1:0]   grant, done;
    logic              busy;

    addr_gen_sched_if #(.W(W), .ID_W(ID_W)) aif ();

    addr_gen_sched #(.W(W), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .cfg_x_max  (cfg_x_max),
        .cfg_y_max  (cfg_y_max),
        .cfg_x_strd (cfg_x_strd),
        .cfg_y_strd (cfg_y_strd),
        .cfg_offset (cfg_offset),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .aif        (aif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_a [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int r, input logic [W-1:0] xm, input logic [W-1:0] ym,
                           input logic [W-1:0] xs, input logic [W-1:0] ys,
                           input logic [W-1:0] off);
        cfg_x_max [r*W +: W] = xm;
        cfg_y_max [r*W +: W] = ym;
        cfg_x_strd[r*W +: W] = xs;
        cfg_y_strd[r*W +: W] = ys;
        cfg_offset[r*W +: W] = off;
    endtask

    // Called on the first negedge after the grant edge. Consumes n beats,
    // comparing each against exp_a, then checks the done pulse and release.
    task automatic run_scan(input string tag, input int n, input bit toggle,
                            input logic [NREQ-1:0] exp_done);
        int k   = 0;
        int cyc = 0;
        while (k < n && cyc < 100) begin
            aif.addr_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            chk({tag, "_valid"}, 32'(aif.addr_valid), 1);
            if (aif.addr_valid) begin
                chk({tag, "_addr"}, 32'(aif.addr_out), 32'(exp_a[k]));
                if (aif.addr_ready) begin
                    chk({tag, "_last"}, 32'(aif.addr_last), (k == n - 1) ? 1 : 0);
                    k++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        if (k < n) chk({tag, "_timeout"}, 32'(k), 32'(n));
        aif.addr_ready = 1'b1;
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_valid_off"}, 32'(aif.addr_valid), 0);
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(done), 0);
        chk({tag, "_grant_rel"}, 32'(grant), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        logic [NREQ-1:0] rr_exp [3];
        int t;

        rst = 1'b1;
        req = '0;
        aif.addr_ready = 1'b1;
        cfg_x_max = '0; cfg_y_max = '0; cfg_x_strd = '0; cfg_y_strd = '0; cfg_offset = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(aif.addr_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(aif.addr_out), 0);
        chk("rst_last", 32'(aif.addr_last), 0);
        chk("rst_id", 32'(aif.addr_id), 0);
        rst = 1'b0;
        @(negedge clk);

        // 3x2 scan, ready always high
        exp_a[0] = 16'd100; exp_a[1] = 16'd101; exp_a[2] = 16'd102;
        exp_a[3] = 16'd107; exp_a[4] = 16'd108; exp_a[5] = 16'd109;
        set_cfg(0, 16'd3, 16'd2, 16'd1, 16'd5, 16'd100);
        req = 2'b01;
        @(negedge clk);
        chk("s1_grant", 32'(grant), 32'h1);
        chk("s1_busy", 32'(busy), 1);
        chk("s1_id", 32'(aif.addr_id), 0);
        req = '0;
        run_scan("s1", 6, 1'b0, 2'b01);

        // Same scan with ready toggling; cfg scrambled after grant is ignored
        req = 2'b01;
        @(negedge clk);
        chk("s2_grant", 32'(grant), 32'h1);
        req = '0;
        set_cfg(0, 16'd9, 16'd9, 16'd7, 16'd7, 16'd500);
        run_scan("s2", 6, 1'b1, 2'b01);

        // 1x1 scan: single last beat at offset
        exp_a[0] = 16'h1234;
        set_cfg(0, 16'd1, 16'd1, 16'd3, 16'd3, 16'h1234);
        req = 2'b01;
        @(negedge clk);
        req = '0;
        run_scan("s1x1", 1, 1'b0, 2'b01);

        // Address wrap through 2^W
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        set_cfg(0, 16'd4, 16'd1, 16'd1, 16'd0, 16'hFFFE);
        req = 2'b01;
        @(negedge clk);
        req = '0;
        run_scan("wrap", 4, 1'b0, 2'b01);

        // Empty scan on requester 1: DONE directly after grant, no beats
        set_cfg(1, 16'd3, 16'd0, 16'd1, 16'd1, 16'd0);
        req = 2'b10;
        @(negedge clk);
        chk("zero_grant", 32'(grant), 32'h2);
        chk("zero_valid", 32'(aif.addr_valid), 0);
        chk("zero_done", 32'(done), 32'h2);
        chk("zero_id", 32'(aif.addr_id), 1);
        req = '0;
        @(negedge clk);
        chk("zero_done_clr", 32'(done), 0);
        chk("zero_grant_rel", 32'(grant), 0);

        // Round robin with both requests held from reset
        set_cfg(0, 16'd1, 16'd1, 16'd0, 16'd0, 16'h0010);
        set_cfg(1, 16'd1, 16'd1, 16'd0, 16'd0, 16'h0020);
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
        rst = 1'b1;
        req = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            t = 0;
            while (grant == '0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("rr_grant", 32'(grant), 32'(rr_exp[g]));
            chk("rr_id", 32'(aif.addr_id), (g == 1) ? 1 : 0);
            chk("rr_addr", 32'(aif.addr_out), (g == 1) ? 32'h20 : 32'h10);
            t = 0;
            while (grant != '0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("rr_release", 32'(grant), 0);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Reset mid-RUN aborts with no done pulse
        set_cfg(0, 16'd3, 16'd2, 16'd1, 16'd5, 16'd100);
        aif.addr_ready = 1'b0;
        req = 2'b01;
        @(negedge clk);
        req = '0;
        chk("abort_run", 32'(aif.addr_valid), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(aif.addr_valid), 0);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_done", 32'(done), 0);
        rst = 1'b0;
        aif.addr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
            chk("abort_stay_idle", 32'(busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
